// File: rtl/ysyx_24110015_pkg.sv
// Shared types for the IFU/LSU AXI-lite arbiter: FSM states and grant encodings.
package ysyx_24110015_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IFU_RD = 2'b01,
      LSU_RD = 2'b10,
      LSU_WR = 2'b11
   } arb_state_t;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_IFU  = 2'b01;
   localparam logic [1:0] GNT_LSU  = 2'b10;

   localparam int REQ_IFU = 0;
   localparam int REQ_LSU = 1;

   // Both LSU states report the LSU as owner; grant does not distinguish read/write.
   function automatic logic [1:0] grant_of(input arb_state_t s);
      case (s)
         IFU_RD:         return GNT_IFU;
         LSU_RD, LSU_WR: return GNT_LSU;
         default:        return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_24110015_axi_lite_if.sv
// AXI-lite bundle shared by the IFU, the LSU and the downstream crossbar port.
interface axi_lite_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_24110015_rr_arb2.sv
// Two-way round-robin picker; 'last' remembers the previous winner (0 IFU, 1 LSU).
module ysyx_24110015_rr_arb2
   import ysyx_24110015_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt[REQ_IFU] = 1'b1;
         2'b10:   gnt[REQ_LSU] = 1'b1;
         2'b11:   if (last) gnt[REQ_IFU] = 1'b1; else gnt[REQ_LSU] = 1'b1;
         default: gnt = 2'b00;
      endcase
   end

   // Reset to LSU so the IFU wins the first conflict after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last <= 1'b1;
      else if (update && (gnt != 2'b00))
         last <= gnt[REQ_LSU];
   end

endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Shares the downstream AXI-lite port between IFU (read-only) and LSU, one whole
// transaction per grant, round-robin between the two requesters.
//
// state  | meaning
// IDLE   | no owner, requests evaluated this cycle
// IFU_RD | IFU AR/R wired to axi_out until R handshake
// LSU_RD | LSU AR/R wired to axi_out until R handshake
// LSU_WR | LSU AW/W/B wired to axi_out until B handshake
module ysyx_24110015_axi_arbiter
   import ysyx_24110015_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   axi_lite_if.slave  axi_ifu,
   axi_lite_if.slave  axi_lsu,
   axi_lite_if.master axi_out,
   output logic [1:0] grant
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t state, state_nxt;
   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   logic       arb_update;

   assign arb_req[REQ_IFU] = axi_ifu.arvalid;
   assign arb_req[REQ_LSU] = axi_lsu.arvalid | axi_lsu.awvalid;

   ysyx_24110015_rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    (arb_req),
      .update (arb_update),
      .gnt    (arb_gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // LSU read beats LSU write when both are offered in the same cycle.
   always_comb begin
      state_nxt  = state;
      arb_update = 1'b0;
      case (state)
         IDLE: begin
            if (arb_req != 2'b00) begin
               arb_update = 1'b1;
               if (arb_gnt[REQ_IFU])
                  state_nxt = IFU_RD;
               else if (axi_lsu.arvalid)
                  state_nxt = LSU_RD;
               else
                  state_nxt = LSU_WR;
            end
         end
         IFU_RD, LSU_RD: if (axi_out.rvalid && axi_out.rready) state_nxt = IDLE;
         LSU_WR:         if (axi_out.bvalid && axi_out.bready) state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   assign grant = grant_of(state);

   always_comb begin
      axi_out.araddr  = {ADDR_W{1'b0}};
      axi_out.arvalid = 1'b0;
      axi_out.rready  = 1'b0;
      axi_out.awaddr  = {ADDR_W{1'b0}};
      axi_out.awvalid = 1'b0;
      axi_out.wdata   = {DATA_W{1'b0}};
      axi_out.wstrb   = {STRB_W{1'b0}};
      axi_out.wvalid  = 1'b0;
      axi_out.bready  = 1'b0;

      axi_ifu.arready = 1'b0;
      axi_ifu.rdata   = {DATA_W{1'b0}};
      axi_ifu.rresp   = 2'b00;
      axi_ifu.rvalid  = 1'b0;
      axi_ifu.awready = 1'b0;
      axi_ifu.wready  = 1'b0;
      axi_ifu.bresp   = 2'b00;
      axi_ifu.bvalid  = 1'b0;

      axi_lsu.arready = 1'b0;
      axi_lsu.rdata   = {DATA_W{1'b0}};
      axi_lsu.rresp   = 2'b00;
      axi_lsu.rvalid  = 1'b0;
      axi_lsu.awready = 1'b0;
      axi_lsu.wready  = 1'b0;
      axi_lsu.bresp   = 2'b00;
      axi_lsu.bvalid  = 1'b0;

      case (state)
         IFU_RD: begin
            axi_out.araddr  = axi_ifu.araddr;
            axi_out.arvalid = axi_ifu.arvalid;
            axi_ifu.arready = axi_out.arready;
            axi_ifu.rdata   = axi_out.rdata;
            axi_ifu.rresp   = axi_out.rresp;
            axi_ifu.rvalid  = axi_out.rvalid;
            axi_out.rready  = axi_ifu.rready;
         end
         LSU_RD: begin
            axi_out.araddr  = axi_lsu.araddr;
            axi_out.arvalid = axi_lsu.arvalid;
            axi_lsu.arready = axi_out.arready;
            axi_lsu.rdata   = axi_out.rdata;
            axi_lsu.rresp   = axi_out.rresp;
            axi_lsu.rvalid  = axi_out.rvalid;
            axi_out.rready  = axi_lsu.rready;
         end
         LSU_WR: begin
            axi_out.awaddr  = axi_lsu.awaddr;
            axi_out.awvalid = axi_lsu.awvalid;
            axi_lsu.awready = axi_out.awready;
            axi_out.wdata   = axi_lsu.wdata;
            axi_out.wstrb   = axi_lsu.wstrb;
            axi_out.wvalid  = axi_lsu.wvalid;
            axi_lsu.wready  = axi_out.wready;
            axi_lsu.bresp   = axi_out.bresp;
            axi_lsu.bvalid  = axi_out.bvalid;
            axi_out.bready  = axi_lsu.bready;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/ysyx_24110015_axi_arbiter.md
# ysyx_24110015_axi_arbiter

Two-to-one AXI-lite arbiter that shares the single downstream AXI-lite master path (toward the CLINT/memory crossbar) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It grants one whole transaction at a time, from address handshake to response handshake, and uses round-robin between requesters. It sits between the IFU/LSU and the crossbar input.

## Interface
Parameters:
- `ADDR_W`, 32, address width carried by the `axi_lite_if` bundles
- `DATA_W`, 32, data width; `wstrb` is `DATA_W/8`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `axi_ifu`  `axi_lite_if.slave`  bundle  IFU requester; only AR/R used
- `axi_lsu`  `axi_lite_if.slave`  bundle  LSU requester; AR/R/AW/W/B used
- `axi_out`  `axi_lite_if.master`  bundle  downstream port to crossbar
- `grant`  out  2  current owner: 00 none, 01 IFU, 10 LSU (debug/perf)

## Operation
- States:
  - `IDLE`: no owner.
  - `IFU_RD`: IFU read granted.
  - `LSU_RD`: LSU read granted.
  - `LSU_WR`: LSU write granted.
- Requests seen in `IDLE`:
  - IFU request = `axi_ifu.arvalid`.
  - LSU request = `axi_lsu.arvalid | axi_lsu.awvalid`.
  - LSU with both `arvalid` and `awvalid` set: read wins (`LSU_RD`).
- Arbitration (round-robin):
  - 1-bit `last` register: 0 = IFU, 1 = LSU.
  - Single requester: that requester is granted.
  - Both requesting: the one not equal to `last` is granted.
  - `last` is updated on the transition out of `IDLE`.
- `IDLE` -> grant state on the edge where a request is present. Otherwise stay in `IDLE`.
- `IFU_RD` / `LSU_RD`:
  - Owner's AR and R channels are wired through combinationally to `axi_out`.
  - Return to `IDLE` on the edge where `axi_out.rvalid & axi_out.rready`.
- `LSU_WR`:
  - LSU AW, W and B channels are wired through to `axi_out`.
  - AW and W may complete in either order or together.
  - Return to `IDLE` on `axi_out.bvalid & axi_out.bready`.
- Non-owner port: all ready/valid outputs 0; `rdata`/`rresp`/`bresp` 0.
- IFU AW/W/B are never forwarded:
  - `axi_ifu.awready`, `wready` and `bvalid` are held 0.
  - IFU write attempts stall forever. Treated as a design error; the bench flags it.
- Address, data and strobe fields on `axi_out`:
  - Muxed from the owner.
  - Driven 0 in `IDLE`.
- Requesters must hold `valid` and payload stable until handshake (AXI rule). The arbiter does not latch payloads.
- Response `rresp`/`bresp` are passed through unmodified; errors do not alter sequencing.

## Timing
- Reset (`rst`=0, asynchronous):
  - `state`=`IDLE`, `last`=1 (so the IFU wins the first conflict), `grant`=00.
  - All ready/valid outputs on all ports are 0.
- Reset asserted mid-transaction:
  - Immediate return to `IDLE`.
  - The downstream transaction is abandoned; no response is forwarded.
- Arbitration latency: request present at edge N -> owner's `arvalid`/`awvalid` visible on `axi_out` from cycle N+1 (1 cycle).
- Within a grant, pass-through is combinational (0 added cycles per channel).
- Back-to-back: response handshake at edge M -> `IDLE` during cycle M+1 -> next grant forwarded from cycle M+2. This is a 1-cycle bubble.
- A request that arrives during a grant waits; it is evaluated in the next `IDLE` cycle.
- `grant` is registered: it equals the state encoding and changes only on edges.

## Structure
- Shared package `ysyx_24110015_pkg` holds:
  - `arb_state_t` enum (`IDLE`, `IFU_RD`, `LSU_RD`, `LSU_WR`).
  - Grant encodings.
- Sub-module `ysyx_24110015_rr_arb2`:
  - 2-way round-robin picker: inputs `req[1:0]`, `update`; output one-hot `gnt[1:0]`.
  - Owns the `last` register, with the same `clk`/`rst`.
- Top level holds the FSM and the channel muxes.

## Test plan
- Reset release, then IFU `araddr`=0x8000_0000 alone -> `axi_out.arvalid` at cycle +1, `grant`=01. Slave returns `rdata`=0x0000_0413 -> IFU receives it; state `IDLE` the next cycle.
- IFU and LSU both raise `arvalid` in the same cycle, repeated 4 times back-to-back -> grants alternate IFU, LSU, IFU, LSU. Each grant begins exactly 2 cycles after the previous R handshake.
- LSU write `awaddr`=0xa000_0048, `wdata`=0x1234_5678, `wstrb`=0xF, with W asserted 3 cycles after AW -> both forwarded; `grant` stays 10 until `bvalid&bready`. IFU `arvalid` raised mid-write is held off until then.
- LSU asserts `arvalid` and `awvalid` together -> read is served first (`grant`=10 in `LSU_RD`). The write follows as a separate grant.
- Downstream `rresp`=2'b10 (SLVERR) -> passed unchanged to the owner; arbitration continues normally.
- `rst` pulled to 0 while in `LSU_WR` before B -> all outputs 0 immediately. After release, state is `IDLE` and IFU wins the first conflict.
